// File: rtl/comparator_pkg.sv
// Shared definitions for the sequential magnitude comparator: result codes
// (compatible with the original 8-bit combinational comparator) and FSM states.
package comparator_pkg;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_GT = 2'd1,
    CMP_LT = 2'd2
  } cmp_code_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Width of an index able to address n items; never zero so a
  // single-chunk configuration still gets a legal 1-bit register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : comparator_pkg

// File: rtl/comparator_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice, returning the
// shared 2-bit result code.
module comparator_chunk
  import comparator_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [1:0]       code
);

  // Magnitude relation of the two slices.
  // NOTE: code gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    code = CMP_EQ;
    if (a > b) begin
      code = CMP_GT;
    end else if (a < b) begin
      code = CMP_LT;
    end
  end

endmodule : comparator_chunk

// File: rtl/comparator_seq_nbits.sv
// Multi-cycle WIDTH-bit magnitude comparator. Operands are captured on start
// and compared one CHUNK-bit slice per cycle from the MSB slice downwards,
// stopping at the first slice that differs. Signed mode flips the sign bit of
// both operands at capture so the unsigned slice compare yields signed order.
module comparator_seq_nbits
  import comparator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  mode,
  input  logic [WIDTH-1:0]                      in1,
  input  logic [WIDTH-1:0]                      in2,
  output logic                                  busy,
  output logic                                  done,
  output logic [1:0]                            out,
  output logic [$clog2(WIDTH/CHUNK+1)-1:0]      count
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = $clog2(NCHUNK + 1);
  localparam int IDX_W  = idx_width(NCHUNK);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [1:0]         out_q, out_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [CHUNK-1:0]   a_chunk, b_chunk;
  logic [1:0]         chunk_code;

  // Select the slice currently under comparison.
  always_comb begin
    a_chunk = a_q[int'(idx_q)*CHUNK +: CHUNK];
    b_chunk = b_q[int'(idx_q)*CHUNK +: CHUNK];
  end

  comparator_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (a_chunk),
    .b    (b_chunk),
    .code (chunk_code)
  );

  // Next-state logic: capture in IDLE, walk slices MSB-first in RUN.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    out_d   = out_q;
    count_d = count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d = in1;
          b_d = in2;
          if (mode) begin
            a_d[WIDTH-1] = ~in1[WIDTH-1];
            b_d[WIDTH-1] = ~in2[WIDTH-1];
          end
          idx_d   = IDX_W'(NCHUNK - 1);
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (chunk_code != CMP_EQ) begin
          out_d   = chunk_code;
          count_d = cnt_q + 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (idx_q == '0) begin
          out_d   = CMP_EQ;
          count_d = CNT_W'(NCHUNK);
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values. The operand registers are reset too, because a cleared
  // operand state is part of the defined reset behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      out_q   <= CMP_EQ;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      out_q   <= out_d;
      count_q <= count_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign out   = out_q;
  assign count = count_q;

endmodule : comparator_seq_nbits

// File: tb/tb_comparator_seq_nbits.sv
// Self-checking bench for comparator_seq_nbits (WIDTH=32, CHUNK=8).
// A transaction-level model predicts busy/done/out/count each cycle from
// plain signed/unsigned arithmetic; directed cases pin literal results.
module tb_comparator_seq_nbits;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = $clog2(NCHUNK + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] in1 = '0;
  logic [WIDTH-1:0] in2 = '0;
  logic             busy;
  logic             done;
  logic [1:0]       out;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  comparator_seq_nbits #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .in1   (in1),
    .in2   (in2),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result: order from arithmetic compare, chunk count from the
  // position of the first differing slice counted from the MSB.
  function automatic void ref_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic md, output int code, output int n);
    logic gt;
    gt   = md ? ($signed(a) > $signed(b)) : (a > b);
    code = (a == b) ? 0 : (gt ? 1 : 2);
    n    = NCHUNK;
    for (int i = 0; i < NCHUNK; i++) begin
      if (a[WIDTH-1-i*CHUNK -: CHUNK] != b[WIDTH-1-i*CHUNK -: CHUNK]) begin
        n = i + 1;
        break;
      end
    end
  endfunction

  // Cycle model: a compare accepted while idle finishes n edges later.
  int m_busy = 0, m_done = 0, m_out = 0, m_count = 0;
  int m_rem = 0, p_out = 0, p_cnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_out = 0; m_count = 0; m_rem = 0;
    end else begin
      m_done = 0;
      if (m_busy != 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0; m_done = 1; m_out = p_out; m_count = p_cnt;
        end
      end else if (start) begin
        ref_cmp(in1, in2, mode, p_out, p_cnt);
        m_rem  = p_cnt;
        m_busy = 1;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy",  32'(busy),  32'(m_busy));
      check("model_done",  32'(done),  32'(m_done));
      check("model_out",   32'(out),   32'(m_out));
      check("model_count", 32'(count), 32'(m_count));
    end
  end

  // Issue one compare and check its literal result and latency.
  task automatic run_case(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic md, input int eo, input int ec, input int elat);
    int lat;
    @(negedge clk);
    in1 = a; in2 = b; mode = md; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_done"},  32'(done),  32'd1);
    check({name, "_lat"},   32'(lat),   32'(elat));
    check({name, "_out"},   32'(out),   32'(eo));
    check({name, "_count"}, 32'(count), 32'(ec));
  endtask

  initial begin
    int lat, busy_cycles, dones;
    #2;
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_out",   32'(out),   32'd0);
    check("rst_count", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Case 1: equal operands, full walk; busy high exactly NCHUNK cycles.
    @(negedge clk);
    in1 = 32'h1234_5678; in2 = 32'h1234_5678; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; busy_cycles = 0;
    if (busy) busy_cycles++;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cycles++;
    end
    check("eq_done",  32'(done),  32'd1);
    check("eq_lat",   32'(lat),   32'd4);
    check("eq_busy",  32'(busy_cycles), 32'd4);
    check("eq_out",   32'(out),   32'd0);
    check("eq_count", 32'(count), 32'd4);

    run_case("msb_gt",    32'hFF00_0000, 32'h0100_0000, 1'b0, 1, 1, 1);
    run_case("lsb_lt",    32'h0000_0009, 32'h0000_000A, 1'b0, 2, 4, 4);
    run_case("sgn_lt",    32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 2, 1, 1);
    run_case("uns_gt",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1, 1, 1);
    run_case("sgn_maxmin",32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1, 1, 1);
    run_case("sgn_negneg",32'hFFFF_FF00, 32'hFFFF_FF01, 1'b1, 2, 4, 4);
    run_case("sgn_eq",    32'h8000_0000, 32'h8000_0000, 1'b1, 0, 4, 4);
    run_case("mid_lt",    32'h1234_0000, 32'h1235_0000, 1'b0, 2, 2, 2);

    // Case 5: start and operand changes while busy are ignored.
    @(negedge clk);
    in1 = 32'h1020_3040; in2 = 32'h1020_3041; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    in1 = 32'hFFFF_FFFF; in2 = 32'h0; mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ign_done",  32'(done),  32'd1);
    check("ign_lat",   32'(lat),   32'd4);
    check("ign_out",   32'(out),   32'd2);
    check("ign_count", 32'(count), 32'd4);
    // Start on the done cycle is accepted.
    in1 = 32'hFF00_0000; in2 = 32'h0100_0000; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("b2b_done",  32'(done),  32'd1);
    check("b2b_out",   32'(out),   32'd1);
    check("b2b_count", 32'(count), 32'd1);

    // Case 6: asynchronous reset in the 2nd run cycle aborts the compare.
    @(negedge clk);
    in1 = 32'h1234_5678; in2 = 32'h1234_5678; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_done",  32'(done),  32'd0);
    check("abort_out",   32'(out),   32'd0);
    check("abort_count", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_comparator_seq_nbits
